operand_stream_scheduler: RTL and testbench
===========================================

# operand_stream_scheduler

Upstream feeder for the PE systolic chain. Buffers matrix-A column words and matrix-B row words from two independent valid/ready source streams. Replays them into the chain's A and B entry ports in the k-major order the PEs consume: for each k, 2^A_NUM_WIDTH A words, then 2^B_NUM_WIDTH B words. Emission is throttled by the chain's full flag, and the block signals completion after N k-steps.

## Interface
- D_WIDTH, 64, operand word width
- A_NUM_WIDTH, 3, log2 of A words per k-step (A_NUM = 1<<A_NUM_WIDTH)
- B_NUM_WIDTH, 3, log2 of B words per k-step (B_NUM = 1<<B_NUM_WIDTH)
- N_MAX_WIDTH, 32, width of the k-step count
- FIFO_DEPTH_WIDTH, 4, log2 of each input FIFO depth (DEPTH = 16)

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- start_in  in  1  one-cycle pulse; latches N_in, begins a job
- N_in  in  N_MAX_WIDTH  number of k-steps
- a_data_in  in  D_WIDTH  A source word
- a_valid_in  in  1  A source valid
- a_ready_out  out  1  A FIFO can accept
- b_data_in  in  D_WIDTH  B source word
- b_valid_in  in  1  B source valid
- b_ready_out  out  1  B FIFO can accept
- full_flag_in  in  1  chain backpressure; high = do not emit
- A_out  out  D_WIDTH  to chain A_in
- A_valid_out  out  1  to chain A_valid_in
- B_out  out  D_WIDTH  to chain B_in
- B_valid_out  out  1  to chain B_valid_in
- busy_out  out  1  job in progress
- done_out  out  1  one-cycle completion pulse

## Operation
- Two synchronous FIFOs (A, B), DEPTH entries each, with an occupancy count of FIFO_DEPTH_WIDTH+1 bits.
- Push occurs when valid && ready. ready = (count != DEPTH). Ready is not relaxed by a same-cycle pop.
- FIFOs accept data in any state, so they can be preloaded before start_in.
- FSM states: IDLE, STREAM_A, STREAM_B, DONE.
- IDLE: on start_in, latch N into n_reg and clear k_cnt and word_cnt.
  - N==0: go to DONE.
  - Otherwise: go to STREAM_A.
  - start_in is ignored in all other states.
- STREAM_A: a pop fires when A FIFO is non-empty and full_flag_in is low. Each pop increments word_cnt.
  - When the pop with word_cnt == A_NUM-1 fires, clear word_cnt and go to STREAM_B.
- STREAM_B: same rule on the B FIFO with B_NUM.
  - On the last B pop with k_cnt == n_reg-1, go to DONE.
  - Otherwise, increment k_cnt and go to STREAM_A.
- DONE: one cycle, then IDLE.
- Empty FIFO or full_flag_in high stalls the current state. Counters hold and no word is lost or duplicated.
- Output stage: one register per side.
  - A_valid_out(t+1) = A pop at t, and A_out is loaded with the popped word.
  - When no pop occurs, A_out holds its last value and A_valid_out is 0. B side is identical.
- A_valid_out and B_valid_out are never high in the same cycle.
- k_cnt and n_reg are N_MAX_WIDTH wide; N up to 2^N_MAX_WIDTH-1 is supported without wrap.
- Reset (asynchronous, any time, including mid-job):
  - FIFOs are flushed, FSM goes to IDLE, all counters clear.
  - Reset values: A_out=0, B_out=0, A_valid_out=0, B_valid_out=0, busy_out=0, done_out=0, a_ready_out=1, b_ready_out=1 (ready derives from count=0).

## Timing
- start_in sampled at edge 0 → STREAM_A in cycle 1. If A data is present, the first pop is in cycle 1 and A_valid_out is high in cycle 2.
- A word pushed at edge t is poppable at cycle t+1, so the minimum FIFO-in to A_valid_out latency is 2 cycles.
- There is no bubble at A→B or B→A transitions. With full FIFOs and full_flag_in low, valid beats are contiguous: N*(A_NUM+B_NUM) beats.
- full_flag_in is used combinationally in the pop decision. A beat popped in the cycle full_flag_in rises is suppressed (not popped), so no beat issues in the following cycle.
- busy_out is high from cycle 1 after start through the last pop cycle, and low in DONE.
- done_out is high in the DONE cycle, which coincides with the final B_valid_out beat. For N==0, done_out is high in cycle 1 and no beats are emitted.

## Test plan
- Preload 8 A words (0x10..0x17) and 8 B words (0x20..0x27); N=1; start → A_valid_out cycles 2-9 with 0x10..0x17, B_valid_out cycles 10-17 with 0x20..0x27, done_out in cycle 17, busy_out low from cycle 17.
- N=3, sources streaming continuously with random valid gaps, full_flag_in low → exactly 24 A and 24 B beats in order A8,B8,A8,B8,A8,B8; values match a scoreboard; one done_out pulse.
- full_flag_in high for cycles 5-9 during the A phase → no valid beats are emitted for the cycles those stalled pops would have produced, emission resumes after full_flag_in falls, and no word is dropped or duplicated.
- Push 17 A words back-to-back with no job running → a_ready_out goes low after the 16th accept, and the 17th is held at the source until one pop occurs.
- N=0 start → done_out is high in cycle 1, no valid beats, and the FIFOs are untouched. A start_in asserted mid-job is ignored, and the beat count is unchanged.
- Assert rst in the middle of the STREAM_B phase → all outputs go to their reset values immediately, FIFO counts return to 0, and a new N=1 job afterwards runs cleanly.

Source files
------------

// File: rtl/operand_stream_scheduler.sv
// Operand feeder for the PE systolic chain: buffers A/B source streams in two
// FIFOs and replays them k-major (A_NUM A words, then B_NUM B words, per k-step).

module oss_fifo #(
   parameter int W  = 64,
   parameter int AW = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push_i,
   input  logic [W-1:0] data_i,
   input  logic         pop_i,
   output logic [W-1:0] data_o,
   output logic         ready_o,
   output logic         nonempty_o
);
   localparam int DEPTH = 1 << AW;
   localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

   logic [W-1:0]  mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q;
   logic [AW-1:0] rd_ptr_q;
   logic [AW:0]   count_q;

   // Storage carries no reset; the pointers and count define which entries are live.
   always_ff @(posedge clk) begin
      if (push_i) begin
         mem_q[wr_ptr_q] <= data_i;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push_i) begin
            wr_ptr_q <= wr_ptr_q + {{(AW-1){1'b0}}, 1'b1};
         end
         if (pop_i) begin
            rd_ptr_q <= rd_ptr_q + {{(AW-1){1'b0}}, 1'b1};
         end
         count_q <= count_q + {{AW{1'b0}}, push_i} - {{AW{1'b0}}, pop_i};
      end
   end

   // Ready ignores a same-cycle pop so it depends on registered state only.
   assign ready_o    = (count_q != DEPTH_C);
   assign nonempty_o = (count_q != '0);
   assign data_o     = mem_q[rd_ptr_q];
endmodule

module operand_stream_scheduler #(
   parameter int D_WIDTH          = 64,
   parameter int A_NUM_WIDTH      = 3,
   parameter int B_NUM_WIDTH      = 3,
   parameter int N_MAX_WIDTH      = 32,
   parameter int FIFO_DEPTH_WIDTH = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start_in,
   input  logic [N_MAX_WIDTH-1:0] N_in,
   input  logic [D_WIDTH-1:0]     a_data_in,
   input  logic                   a_valid_in,
   output logic                   a_ready_out,
   input  logic [D_WIDTH-1:0]     b_data_in,
   input  logic                   b_valid_in,
   output logic                   b_ready_out,
   input  logic                   full_flag_in,
   output logic [D_WIDTH-1:0]     A_out,
   output logic                   A_valid_out,
   output logic [D_WIDTH-1:0]     B_out,
   output logic                   B_valid_out,
   output logic                   busy_out,
   output logic                   done_out
);
   localparam int WC_W = (A_NUM_WIDTH > B_NUM_WIDTH) ? A_NUM_WIDTH : B_NUM_WIDTH;
   localparam logic [WC_W-1:0] A_LAST = WC_W'((1 << A_NUM_WIDTH) - 1);
   localparam logic [WC_W-1:0] B_LAST = WC_W'((1 << B_NUM_WIDTH) - 1);

   typedef enum logic [1:0] {
      S_IDLE     = 2'd0,
      S_STREAM_A = 2'd1,
      S_STREAM_B = 2'd2,
      S_DONE     = 2'd3
   } state_t;

   state_t                 state_q, state_d;
   logic [N_MAX_WIDTH-1:0] n_q, n_d;
   logic [N_MAX_WIDTH-1:0] k_q, k_d;
   logic [WC_W-1:0]        wc_q, wc_d;
   logic [D_WIDTH-1:0]     a_out_q, b_out_q;
   logic                   a_valid_q, b_valid_q, busy_q, done_q;

   logic               a_push, b_push, a_pop, b_pop;
   logic               a_nonempty, b_nonempty;
   logic [D_WIDTH-1:0] a_head, b_head;

   assign a_push = a_valid_in && a_ready_out;
   assign b_push = b_valid_in && b_ready_out;

   oss_fifo #(.W(D_WIDTH), .AW(FIFO_DEPTH_WIDTH)) u_a_fifo (
      .clk        (clk),
      .rst        (rst),
      .push_i     (a_push),
      .data_i     (a_data_in),
      .pop_i      (a_pop),
      .data_o     (a_head),
      .ready_o    (a_ready_out),
      .nonempty_o (a_nonempty)
   );

   oss_fifo #(.W(D_WIDTH), .AW(FIFO_DEPTH_WIDTH)) u_b_fifo (
      .clk        (clk),
      .rst        (rst),
      .push_i     (b_push),
      .data_i     (b_data_in),
      .pop_i      (b_pop),
      .data_o     (b_head),
      .ready_o    (b_ready_out),
      .nonempty_o (b_nonempty)
   );

   // Sequencing: full_flag_in gates the pop combinationally, so a stall holds every counter.
   always_comb begin
      state_d = state_q;
      n_d     = n_q;
      k_d     = k_q;
      wc_d    = wc_q;
      a_pop   = 1'b0;
      b_pop   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start_in) begin
               n_d     = N_in;
               k_d     = '0;
               wc_d    = '0;
               state_d = (N_in == '0) ? S_DONE : S_STREAM_A;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_STREAM_A: begin
            a_pop = a_nonempty && !full_flag_in;
            if (a_pop && (wc_q == A_LAST)) begin
               wc_d    = '0;
               state_d = S_STREAM_B;
            end else if (a_pop) begin
               wc_d = wc_q + {{(WC_W-1){1'b0}}, 1'b1};
            end else begin
               wc_d = wc_q;
            end
         end
         S_STREAM_B: begin
            b_pop = b_nonempty && !full_flag_in;
            if (b_pop && (wc_q == B_LAST)) begin
               wc_d = '0;
               if (k_q == (n_q - N_MAX_WIDTH'(1))) begin
                  state_d = S_DONE;
               end else begin
                  k_d     = k_q + N_MAX_WIDTH'(1);
                  state_d = S_STREAM_A;
               end
            end else if (b_pop) begin
               wc_d = wc_q + {{(WC_W-1){1'b0}}, 1'b1};
            end else begin
               wc_d = wc_q;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         n_q     <= '0;
         k_q     <= '0;
         wc_q    <= '0;
      end else begin
         state_q <= state_d;
         n_q     <= n_d;
         k_q     <= k_d;
         wc_q    <= wc_d;
      end
   end

   // Output stage: data registers hold their last word, status flags follow the next state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_out_q   <= '0;
         b_out_q   <= '0;
         a_valid_q <= 1'b0;
         b_valid_q <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         a_valid_q <= a_pop;
         b_valid_q <= b_pop;
         if (a_pop) begin
            a_out_q <= a_head;
         end
         if (b_pop) begin
            b_out_q <= b_head;
         end
         busy_q <= (state_d == S_STREAM_A) || (state_d == S_STREAM_B);
         done_q <= (state_d == S_DONE);
      end
   end

   assign A_out       = a_out_q;
   assign B_out       = b_out_q;
   assign A_valid_out = a_valid_q;
   assign B_valid_out = b_valid_q;
   assign busy_out    = busy_q;
   assign done_out    = done_q;
endmodule

// File: tb/tb_operand_stream_scheduler.sv
// Self-checking bench for operand_stream_scheduler: per-cycle vector table for the
// basic job plus scoreboarded sequences for streaming, backpressure, overflow and reset.

module tb_operand_stream_scheduler;
   localparam int DW = 64;
   localparam int NW = 32;

   logic          clk = 1'b0;
   logic          rst, start_in, a_valid_in, b_valid_in, full_flag_in;
   logic [NW-1:0] N_in;
   logic [DW-1:0] a_data_in, b_data_in;
   logic          a_ready_out, b_ready_out, A_valid_out, B_valid_out, busy_out, done_out;
   logic [DW-1:0] A_out, B_out;

   operand_stream_scheduler #(
      .D_WIDTH(DW), .A_NUM_WIDTH(3), .B_NUM_WIDTH(3), .N_MAX_WIDTH(NW), .FIFO_DEPTH_WIDTH(4)
   ) dut (
      .clk(clk), .rst(rst), .start_in(start_in), .N_in(N_in),
      .a_data_in(a_data_in), .a_valid_in(a_valid_in), .a_ready_out(a_ready_out),
      .b_data_in(b_data_in), .b_valid_in(b_valid_in), .b_ready_out(b_ready_out),
      .full_flag_in(full_flag_in),
      .A_out(A_out), .A_valid_out(A_valid_out), .B_out(B_out), .B_valid_out(B_valid_out),
      .busy_out(busy_out), .done_out(done_out)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic          av;
      logic [DW-1:0] ad;
      logic          bv;
      logic [DW-1:0] bd;
      logic          busy;
      logic          done;
   } vec_t;

   int            nchk = 0;
   int            nerr = 0;
   logic [DW-1:0] qa[$];
   logic [DW-1:0] qb[$];
   bit            seq[$];
   int            a_beats, b_beats, done_cnt;
   vec_t          tbl[19];

   task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      nchk++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Scoreboard monitor: every emitted beat must match the next word pushed on that side.
   always @(negedge clk) begin
      if (!rst) begin
         if (A_valid_out && B_valid_out) check("both_valid", 64'd1, 64'd0);
         if (A_valid_out) begin
            a_beats++;
            seq.push_back(1'b0);
            if (qa.size() == 0) check("a_beat_unexpected", A_out, 64'hx);
            else check("a_beat", A_out, qa.pop_front());
         end
         if (B_valid_out) begin
            b_beats++;
            seq.push_back(1'b1);
            if (qb.size() == 0) check("b_beat_unexpected", B_out, 64'hx);
            else check("b_beat", B_out, qb.pop_front());
         end
         if (done_out) done_cnt++;
      end
   end

   task automatic clear_counts();
      qa.delete();
      qb.delete();
      seq.delete();
      a_beats  = 0;
      b_beats  = 0;
      done_cnt = 0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      start_in = 1'b0; N_in = '0; full_flag_in = 1'b0;
      a_valid_in = 1'b0; b_valid_in = 1'b0; a_data_in = '0; b_data_in = '0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      clear_counts();
   endtask

   task automatic preload(input int na, input int nb, input logic [DW-1:0] abase, input logic [DW-1:0] bbase);
      int n;
      n = (na > nb) ? na : nb;
      for (int i = 0; i < n; i++) begin
         a_valid_in = (i < na); a_data_in = abase + DW'(i);
         b_valid_in = (i < nb); b_data_in = bbase + DW'(i);
         if (a_valid_in && a_ready_out) qa.push_back(a_data_in);
         if (b_valid_in && b_ready_out) qb.push_back(b_data_in);
         @(negedge clk);
      end
      a_valid_in = 1'b0;
      b_valid_in = 1'b0;
   endtask

   // Drives start during cycle 0 and returns while observing cycle 1.
   task automatic start_job(input logic [NW-1:0] n);
      start_in = 1'b1;
      N_in     = n;
      @(negedge clk);
      start_in = 1'b0;
   endtask

   task automatic check_tail(input string tag, input int na, input int nb, input int nd);
      repeat (4) @(negedge clk);
      check({tag, "_a_beats"}, DW'(a_beats), DW'(na));
      check({tag, "_b_beats"}, DW'(b_beats), DW'(nb));
      check({tag, "_done_cnt"}, DW'(done_cnt), DW'(nd));
      check({tag, "_busy_idle"}, DW'(busy_out), 64'd0);
   endtask

   initial begin
      int ai, bi, acc, done_cyc;
      bit seen;

      // ---- Basic N=1 job against a per-cycle vector table ----
      do_reset();
      check("rst_a_out", A_out, 64'd0);
      check("rst_b_out", B_out, 64'd0);
      check("rst_valids", {62'd0, A_valid_out, B_valid_out}, 64'd0);
      check("rst_busy_done", {62'd0, busy_out, done_out}, 64'd0);
      check("rst_ready", {62'd0, a_ready_out, b_ready_out}, 64'd3);
      for (int c = 1; c < 19; c++) begin
         tbl[c].av   = (c >= 2 && c <= 9);
         tbl[c].ad   = (c < 2) ? 64'd0 : (c <= 9) ? 64'h10 + DW'(c - 2) : 64'h17;
         tbl[c].bv   = (c >= 10 && c <= 17);
         tbl[c].bd   = (c < 10) ? 64'd0 : (c <= 17) ? 64'h20 + DW'(c - 10) : 64'h27;
         tbl[c].busy = (c >= 1 && c <= 16);
         tbl[c].done = (c == 17);
      end
      preload(8, 8, 64'h10, 64'h20);
      start_job(32'd1);
      for (int c = 1; c < 19; c++) begin
         check($sformatf("t1_av_c%0d", c), DW'(A_valid_out), DW'(tbl[c].av));
         check($sformatf("t1_ad_c%0d", c), A_out, tbl[c].ad);
         check($sformatf("t1_bv_c%0d", c), DW'(B_valid_out), DW'(tbl[c].bv));
         check($sformatf("t1_bd_c%0d", c), B_out, tbl[c].bd);
         check($sformatf("t1_busy_c%0d", c), DW'(busy_out), DW'(tbl[c].busy));
         check($sformatf("t1_done_c%0d", c), DW'(done_out), DW'(tbl[c].done));
         @(negedge clk);
      end
      check_tail("t1", 8, 8, 1);

      // ---- N=3 with randomly gapped streaming sources ----
      do_reset();
      ai = 0; bi = 0; seen = 1'b0;
      for (int cyc = 0; cyc < 400 && !seen; cyc++) begin
         start_in   = (cyc == 0);
         N_in       = 32'd3;
         a_valid_in = (ai < 24) && ($urandom_range(3) != 0);
         a_data_in  = {$urandom, $urandom};
         b_valid_in = (bi < 24) && ($urandom_range(3) != 0);
         b_data_in  = {$urandom, $urandom};
         if (a_valid_in && a_ready_out) begin qa.push_back(a_data_in); ai++; end
         if (b_valid_in && b_ready_out) begin qb.push_back(b_data_in); bi++; end
         @(negedge clk);
         seen = done_out;
      end
      start_in = 1'b0; a_valid_in = 1'b0; b_valid_in = 1'b0;
      check("t2_done_seen", DW'(seen), 64'd1);
      check_tail("t2", 24, 24, 1);
      check("t2_seq_len", DW'(seq.size()), 64'd48);
      for (int i = 0; i < seq.size() && i < 48; i++) begin
         if (seq[i] != bit'((i / 8) % 2)) check($sformatf("t2_order_%0d", i), DW'(seq[i]), DW'((i / 8) % 2));
      end

      // ---- full_flag_in high for cycles 5-9 during the A phase ----
      do_reset();
      preload(8, 8, 64'h30, 64'h40);
      start_job(32'd1);
      done_cyc = -1;
      for (int c = 1; c < 26; c++) begin
         full_flag_in = (c >= 5 && c <= 9);
         if (c == 5) check("t3_av_c5", DW'(A_valid_out), 64'd1);
         if (c >= 6 && c <= 10) check($sformatf("t3_stall_c%0d", c), DW'(A_valid_out | B_valid_out), 64'd0);
         if (c == 11) check("t3_resume_c11", DW'(A_valid_out), 64'd1);
         if (done_out && done_cyc < 0) done_cyc = c;
         @(negedge clk);
      end
      full_flag_in = 1'b0;
      check("t3_done_cycle", DW'(done_cyc), 64'd22);
      check_tail("t3", 8, 8, 1);

      // ---- 17 back-to-back A pushes with no job running ----
      do_reset();
      acc = 0;
      for (int c = 0; c < 20; c++) begin
         a_valid_in = 1'b1;
         a_data_in  = 64'h100 + DW'(acc);
         if (a_ready_out) begin qa.push_back(a_data_in); acc++; end
         @(negedge clk);
      end
      check("t4_accepted16", DW'(acc), 64'd16);
      check("t4_ready_low", DW'(a_ready_out), 64'd0);
      start_in = 1'b1; N_in = 32'd1;
      done_cyc = -1;
      for (int c = 0; c < 10; c++) begin
         a_valid_in = (acc < 17);
         a_data_in  = 64'h100 + DW'(acc);
         if (a_valid_in && a_ready_out) begin qa.push_back(a_data_in); acc++; done_cyc = c; end
         @(negedge clk);
         start_in = 1'b0;
      end
      a_valid_in = 1'b0;
      check("t4_accepted17", DW'(acc), 64'd17);
      check("t4_accept_cycle", DW'(done_cyc), 64'd2);
      preload(0, 8, 64'd0, 64'h200);
      check_tail("t4", 8, 8, 1);

      // ---- N=0 start, then a mid-job start that must be ignored ----
      do_reset();
      preload(8, 8, 64'h50, 64'h60);
      start_job(32'd0);
      check("t5_n0_done_c1", DW'(done_out), 64'd1);
      check("t5_n0_busy_c1", DW'(busy_out), 64'd0);
      repeat (5) @(negedge clk);
      check("t5_n0_no_beats", DW'(a_beats + b_beats), 64'd0);
      start_job(32'd1);
      for (int c = 1; c < 30; c++) begin
         start_in = (c == 5);
         N_in     = 32'd5;
         if (c == 17) check("t5_done_c17", DW'(done_out), 64'd1);
         @(negedge clk);
      end
      start_in = 1'b0;
      check_tail("t5", 8, 8, 2);

      // ---- Asynchronous reset during STREAM_B, then a clean job ----
      do_reset();
      preload(8, 8, 64'h70, 64'h80);
      start_job(32'd1);
      repeat (11) @(negedge clk);
      check("t6_in_b_phase", DW'(B_valid_out), 64'd1);
      #2 rst = 1'b1;
      #1;
      check("t6_rst_a_out", A_out, 64'd0);
      check("t6_rst_b_out", B_out, 64'd0);
      check("t6_rst_flags", {60'd0, A_valid_out, B_valid_out, busy_out, done_out}, 64'd0);
      check("t6_rst_ready", {62'd0, a_ready_out, b_ready_out}, 64'd3);
      @(negedge clk);
      rst = 1'b0;
      clear_counts();
      preload(8, 8, 64'h90, 64'hA0);
      start_job(32'd1);
      done_cyc = -1;
      for (int c = 1; c < 30; c++) begin
         if (done_out && done_cyc < 0) done_cyc = c;
         @(negedge clk);
      end
      check("t6_done_cycle", DW'(done_cyc), 64'd17);
      check_tail("t6", 8, 8, 1);

      $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got no finish, expected finish before %0t", $time);
      $fatal(1, "timeout");
   end
endmodule
